// File: rtl/sha256_msg_sched_if.sv
// sha256_msg_sched_if: block-in / schedule-word-out handshakes of the SHA-256 message scheduler.
// master is the scheduler side, slave is the block source and round datapath side.
interface sha256_msg_sched_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  blk_valid;
    logic                  blk_ready;
    logic [511:0]          blk_data;
    logic                  w_valid;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_data;
    logic [5:0]            w_idx;
    logic                  w_last;

    modport master (
        input  blk_valid, blk_data, w_ready,
        output blk_ready, w_valid, w_data, w_idx, w_last
    );

    modport slave (
        output blk_valid, blk_data, w_ready,
        input  blk_ready, w_valid, w_data, w_idx, w_last
    );
endinterface

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: streams the 64 SHA-256 schedule words W[0..63] of each 512-bit block.
// Define SHA256_MSG_SCHED_PREFETCH_EN to add a one-block buffer for bubble-free back-to-back blocks.
module sha256_msg_sched #(
    parameter int DATA_WIDTH = 32
) (
    input logic               clk,
    input logic               rst,
    sha256_msg_sched_if.master bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]            state;
    logic                  alive;
    logic [5:0]            t;
    logic [DATA_WIDTH-1:0] win [16];
    logic [DATA_WIDTH-1:0] nxt;
    logic [511:0]          src;
    logic                  blk_fire;
    logic                  w_fire;
    logic                  wrap;
    logic                  load;
`ifdef SHA256_MSG_SCHED_PREFETCH_EN
    logic [511:0]          blk_buf;
    logic                  buf_full;
`endif

    function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (DATA_WIDTH - n));
    endfunction

    function automatic logic [DATA_WIDTH-1:0] s0(input logic [DATA_WIDTH-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] s1(input logic [DATA_WIDTH-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // alive keeps blk_ready low until the first edge after reset release
`ifdef SHA256_MSG_SCHED_PREFETCH_EN
    assign bus.blk_ready = alive && (state == IDLE || !buf_full);
`else
    assign bus.blk_ready = alive && state == IDLE;
`endif
    assign bus.w_valid = state == RUN;
    assign bus.w_data  = win[0];
    assign bus.w_idx   = t;
    assign bus.w_last  = state == RUN && t == 6'd63;

    always_comb begin
        blk_fire = bus.blk_valid && bus.blk_ready;
        w_fire   = bus.w_valid && bus.w_ready;
        wrap     = w_fire && t == 6'd63;
        nxt      = win[0] + s0(win[1]) + win[9] + s1(win[14]);
`ifdef SHA256_MSG_SCHED_PREFETCH_EN
        src      = buf_full ? blk_buf : bus.blk_data;
        load     = state == IDLE ? blk_fire : wrap && (buf_full || blk_fire);
`else
        src      = bus.blk_data;
        load     = state == IDLE && blk_fire;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            alive <= 1'b0;
            t     <= 6'd0;
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else begin
            alive <= 1'b1;
            if (load) begin
                for (int i = 0; i < 16; i++) win[i] <= src[DATA_WIDTH*(15-i) +: DATA_WIDTH];
                t     <= 6'd0;
                state <= RUN;
            end else if (wrap) begin
                state <= IDLE;
            end else if (w_fire) begin
                for (int i = 0; i < 15; i++) win[i] <= win[i+1];
                win[15] <= nxt;
                t       <= t + 6'd1;
            end
        end
    end

`ifdef SHA256_MSG_SCHED_PREFETCH_EN
    // a block arriving on the final-word cycle with an empty buffer goes straight to the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_buf  <= '0;
            buf_full <= 1'b0;
        end else if (load && state == RUN && buf_full) begin
            buf_full <= 1'b0;
        end else if (blk_fire && state == RUN && !wrap) begin
            blk_buf  <= bus.blk_data;
            buf_full <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: randomized self-checking bench for sha256_msg_sched against a FIPS 180-4 schedule model.
`timescale 1ns/1ps
module tb_sha256_msg_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sha256_msg_sched_if bus ();
    sha256_msg_sched dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

    logic [31:0] exp_w [128];
    logic [31:0] got_d [$];
    logic [5:0]  got_i [$];
    int unstable, vcycles, lastbad;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], stored at exp_w[base..base+63]
    task automatic fill_exp(input logic [511:0] b, input int base);
        logic [31:0] w [64];
        for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                 + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
        for (int i = 0; i < 64; i++) exp_w[base+i] = w[i];
    endtask

    function automatic logic [511:0] rand_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_block(input logic [511:0] d, output bit ok);
        int n = 0;
        bus.blk_valid = 1'b1;
        bus.blk_data  = d;
        while (bus.blk_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        ok = bus.blk_ready === 1'b1;
        if (ok) tick();
        bus.blk_valid = 1'b0;
        bus.blk_data  = rand_blk();
    endtask

    // consumes up to n words within budget cycles, recording handshakes and stall/last anomalies
    task automatic run_words(input int n, input bit rnd, input int budget);
        logic [31:0] pd = '0;
        logic [5:0]  pi = '0;
        bit stalled = 1'b0;
        got_d.delete();
        got_i.delete();
        unstable = 0;
        vcycles  = 0;
        lastbad  = 0;
        for (int c = 0; c < budget && got_d.size() < n; c++) begin
            bus.w_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled && (bus.w_valid !== 1'b1 || bus.w_data !== pd || bus.w_idx !== pi)) unstable++;
            if (bus.w_last !== (bus.w_valid === 1'b1 && bus.w_idx === 6'd63)) lastbad++;
            if (bus.w_valid === 1'b1) vcycles++;
            if (bus.w_valid === 1'b1 && bus.w_ready) begin
                got_d.push_back(bus.w_data);
                got_i.push_back(bus.w_idx);
                stalled = 1'b0;
            end else begin
                stalled = bus.w_valid === 1'b1;
                pd = bus.w_data;
                pi = bus.w_idx;
            end
            tick();
        end
        bus.w_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.blk_ready !== 1'b0 || bus.w_valid !== 1'b0 || bus.w_data !== 32'h0 ||
            bus.w_idx !== 6'd0 || bus.w_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b v=%b d=%h i=%0d l=%b required all zero",
                     bus.blk_ready, bus.w_valid, bus.w_data, bus.w_idx, bus.w_last);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.blk_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_early got %b required 0", bus.blk_ready);
        end
        tick();
        checks++;
        if (bus.blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after got %b required 1", bus.blk_ready);
        end
    endtask

    task automatic test_abc();
        bit ok;
        fill_exp(ABC, 0);
        send_block(ABC, ok);
        checks++;
        if (!ok || bus.w_valid !== 1'b1 || bus.w_idx !== 6'd0) begin
            errors++;
            $display("FAIL abc_latency got ok=%b v=%b i=%0d required 1 1 0", ok, bus.w_valid, bus.w_idx);
        end
        run_words(64, 1'b0, 64);
        checks++;
        if (got_d.size() !== 64) begin
            errors++;
            $display("FAIL abc_count got %0d required 64", got_d.size());
        end
        for (int i = 0; i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_w[i] || got_i[i] !== 6'(i)) begin
                errors++;
                $display("FAIL abc_word[%0d] got %h/%0d required %h/%0d", i, got_d[i], got_i[i], exp_w[i], i);
            end
        end
        checks++;
        if (got_d[16] !== 32'h61626380 || got_d[17] !== 32'h000F0000 || got_d[63] !== 32'h12B1EDEB) begin
            errors++;
            $display("FAIL abc_fips got %h %h %h required 61626380 000f0000 12b1edeb",
                     got_d[16], got_d[17], got_d[63]);
        end
        checks++;
        if (lastbad !== 0) begin
            errors++;
            $display("FAIL abc_last got %0d bad cycles required 0", lastbad);
        end
        checks++;
        if (bus.w_valid !== 1'b0 || bus.blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL abc_idle got v=%b rdy=%b required 0 1", bus.w_valid, bus.blk_ready);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int extra = 0;
        fill_exp(ABC, 0);
        send_block(ABC, ok);
        run_words(64, 1'b1, 800);
        checks++;
        if (!ok || got_d.size() !== 64) begin
            errors++;
            $display("FAIL stall_count got ok=%b n=%0d required 1 64", ok, got_d.size());
        end
        for (int i = 0; i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_w[i] || got_i[i] !== 6'(i)) begin
                errors++;
                $display("FAIL stall_word[%0d] got %h/%0d required %h/%0d", i, got_d[i], got_i[i], exp_w[i], i);
            end
        end
        checks++;
        if (unstable !== 0 || lastbad !== 0) begin
            errors++;
            $display("FAIL stall_stable got unstable=%0d lastbad=%0d required 0 0", unstable, lastbad);
        end
        bus.w_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (bus.w_valid === 1'b1) extra++;
            tick();
        end
        bus.w_ready = 1'b0;
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL stall_extra got %0d extra words required 0", extra);
        end
    endtask

    task automatic test_random_blocks();
        bit ok;
        logic [511:0] b;
        for (int k = 0; k < 3; k++) begin
            b = rand_blk();
            fill_exp(b, 0);
            send_block(b, ok);
            run_words(64, 1'b1, 800);
            checks++;
            if (!ok || got_d.size() !== 64 || unstable !== 0 || lastbad !== 0) begin
                errors++;
                $display("FAIL rand%0d_flow got ok=%b n=%0d unstable=%0d lastbad=%0d required 1 64 0 0",
                         k, ok, got_d.size(), unstable, lastbad);
            end
            for (int i = 0; i < got_d.size(); i++) begin
                checks++;
                if (got_d[i] !== exp_w[i] || got_i[i] !== 6'(i)) begin
                    errors++;
                    $display("FAIL rand%0d_word[%0d] got %h/%0d required %h/%0d",
                             k, i, got_d[i], got_i[i], exp_w[i], i);
                end
            end
        end
    endtask

`ifndef SHA256_MSG_SCHED_PREFETCH_EN
    task automatic test_run_block();
        bit ok;
        int low = 0;
        logic [511:0] b;
        send_block(ABC, ok);
        b = rand_blk();
        fill_exp(b, 0);
        bus.blk_valid = 1'b1;
        bus.blk_data  = b;
        bus.w_ready   = 1'b1;
        while (bus.blk_ready !== 1'b1 && low < 200) begin
            low++;
            tick();
        end
        bus.w_ready = 1'b0;
        checks++;
        if (low < 64 || bus.w_valid !== 1'b0) begin
            errors++;
            $display("FAIL run_block_wait got low=%0d v=%b required >=64 0", low, bus.w_valid);
        end
        tick();
        bus.blk_valid = 1'b0;
        bus.blk_data  = rand_blk();
        run_words(64, 1'b0, 64);
        checks++;
        if (got_d.size() !== 64) begin
            errors++;
            $display("FAIL run_block_count got %0d required 64", got_d.size());
        end
        for (int i = 0; i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL run_block_word[%0d] got %h required %h", i, got_d[i], exp_w[i]);
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        bit ok1, ok2;
        fill_exp(ABC, 0);
        fill_exp(ABC, 64);
`ifdef SHA256_MSG_SCHED_PREFETCH_EN
        send_block(ABC, ok1);
        send_block(ABC, ok2);
        checks++;
        if (!ok1 || !ok2 || bus.blk_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept got ok=%b%b rdy=%b required 11 0", ok1, ok2, bus.blk_ready);
        end
        run_words(128, 1'b0, 128);
        checks++;
        if (got_d.size() !== 128 || vcycles !== 128) begin
            errors++;
            $display("FAIL b2b_count got n=%0d vcycles=%0d required 128 128", got_d.size(), vcycles);
        end
        for (int i = 0; i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_w[i] || got_i[i] !== 6'(i % 64)) begin
                errors++;
                $display("FAIL b2b_word[%0d] got %h/%0d required %h/%0d", i, got_d[i], got_i[i], exp_w[i], i % 64);
            end
        end
`else
        send_block(ABC, ok1);
        run_words(64, 1'b0, 64);
        checks++;
        if (!ok1 || got_d.size() !== 64 || bus.w_valid !== 1'b0 || bus.blk_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_bubble got ok=%b n=%0d v=%b rdy=%b required 1 64 0 1",
                     ok1, got_d.size(), bus.w_valid, bus.blk_ready);
        end
        send_block(ABC, ok2);
        run_words(64, 1'b0, 64);
        checks++;
        if (!ok2 || got_d.size() !== 64 || got_d[63] !== exp_w[127]) begin
            errors++;
            $display("FAIL b2b_second got ok=%b n=%0d w63=%h required 1 64 %h", ok2, got_d.size(), got_d[63], exp_w[127]);
        end
`endif
    endtask

    task automatic test_mid_reset();
        bit ok;
        send_block(rand_blk(), ok);
        run_words(20, 1'b0, 20);
        checks++;
        if (!ok || bus.w_valid !== 1'b1 || bus.w_idx !== 6'd20) begin
            errors++;
            $display("FAIL mid_reset_pos got ok=%b v=%b i=%0d required 1 1 20", ok, bus.w_valid, bus.w_idx);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.w_valid !== 1'b0 || bus.w_data !== 32'h0 || bus.w_idx !== 6'd0 ||
            bus.w_last !== 1'b0 || bus.blk_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_outputs got v=%b d=%h i=%0d l=%b rdy=%b required all zero",
                     bus.w_valid, bus.w_data, bus.w_idx, bus.w_last, bus.blk_ready);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (bus.blk_ready !== 1'b1 || bus.w_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_release got rdy=%b v=%b required 1 0", bus.blk_ready, bus.w_valid);
        end
        fill_exp(ABC, 0);
        send_block(ABC, ok);
        run_words(64, 1'b0, 64);
        checks++;
        if (!ok || got_d.size() !== 64 || got_i[0] !== 6'd0) begin
            errors++;
            $display("FAIL mid_reset_restart got ok=%b n=%0d i0=%0d required 1 64 0", ok, got_d.size(), got_i[0]);
        end
        for (int i = 0; i < got_d.size(); i++) begin
            checks++;
            if (got_d[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL mid_reset_word[%0d] got %h required %h", i, got_d[i], exp_w[i]);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.blk_valid = 1'b0;
        bus.blk_data  = '0;
        bus.w_ready   = 1'b0;
        test_reset();
        test_abc();
        test_stall();
        test_random_blocks();
`ifndef SHA256_MSG_SCHED_PREFETCH_EN
        test_run_block();
`endif
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
